// File: rtl/i2c_reg_slave_if.sv
// I2C register-slave bus bundle: pad-side SCL/SDA plus register-bank access.
`timescale 1ns/1ps
interface i2c_reg_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic       wr1rd0;
  logic [7:0] reg_wr_data;
  logic       reg_req;
  logic [7:0] reg_rd_data;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, reg_rd_data,
    output sda_oe, reg_addr, wr1rd0,
    output reg_wr_data, reg_req, busy
  );

  modport master (
    output scl_i, sda_i, reg_rd_data,
    input  sda_oe, reg_addr, wr1rd0,
    input  reg_wr_data, reg_req, busy
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C slave front-end: decodes device/pointer/data bytes into
// single-cycle register-bank strobes and serves reads onto SDA.
`timescale 1ns/1ps
module i2c_reg_slave #(
  parameter logic [6:0] I2C_ADDR    = 7'h01,
  parameter int         SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset_n,
  i2c_reg_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       req_q, req_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] addr_q, addr_d;
  logic       cap_q, cap_d;
  logic       inc_q, inc_d;
  logic       addr_inc;
  logic [7:0] rx_byte;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign rx_byte = {shreg_q[6:0], sda_s};

  // read data lands one clk after the strobe; pointer bumps one clk later
  assign cap_d    = req_q & ~wr_q;
  assign inc_d    = cap_q;
  assign addr_inc = (req_q & wr_q) | inc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = cap_q ? bus.reg_rd_data : shreg_q;
    phase_d  = phase_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    req_d    = 1'b0;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q + {7'd0, addr_inc};
    if (start_det) begin
      state_d  = DEV_ADDR;
      cnt_d    = 4'd0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: begin
        end
        DEV_ADDR, REG_ADDR, WR_DATA: begin
          if (scl_rise) begin
            shreg_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              phase_d = 1'b0;
              if (state_q == DEV_ADDR) begin
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state_d = DEV_ACK;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == REG_ADDR) begin
                addr_d  = rx_byte;
                state_d = REG_ACK;
              end else begin
                req_d   = 1'b1;
                wr_d    = 1'b1;
                wdata_d = rx_byte;
                state_d = WR_ACK;
              end
            end
          end
        end
        DEV_ACK, REG_ACK, WR_ACK: begin
          if (scl_rise && phase_q && rw_q &&
              state_q == DEV_ACK) begin
            req_d = 1'b1;
            wr_d  = 1'b0;
          end
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d  = 1'b0;
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
              if (state_q == DEV_ACK && rw_q) begin
                state_d  = RD_DATA;
                sda_oe_d = ~shreg_q[7];
              end else if (state_q == DEV_ACK) begin
                state_d = REG_ADDR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d = ~shreg_q[6];
              shreg_d  = {shreg_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_s) begin
              req_d   = 1'b1;
              wr_d    = 1'b0;
              phase_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
          if (scl_fall && phase_q) begin
            state_d  = RD_DATA;
            cnt_d    = 4'd0;
            phase_d  = 1'b0;
            sda_oe_d = ~shreg_q[7];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shreg_q    <= 8'd0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 8'd0;
      addr_q     <= 8'd0;
      cap_q      <= 1'b0;
      inc_q      <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      cap_q      <= cap_d;
      inc_q      <= inc_d;
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.reg_addr    = addr_q;
  assign bus.wr1rd0      = wr_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.reg_req     = req_q;
  assign bus.busy        = busy_q;

endmodule
